hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Pipeline hazard controller for the 5-stage core: fetch, decode, execute, mem, writeback.
- Tracks in-flight register writes on a per-register scoreboard and stalls decode on read-after-write hazards, because the core has no forwarding.
- Flushes the wrong-path fetch slot after a taken branch resolved in decode.
- Drives hold/clear/bubble controls into the fetch and decode pipeline registers.

Parameters:
- NREGS, 16, number of architectural registers tracked (all tracked; no hardwired zero register).
- REG_AW, 4, register address width.
- WB_LAT, 3, cycles from issue out of decode until a consumer in decode may read the written value.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- dec_valid  in  1  decode slot holds a real instruction
- dec_rs1  in  4  source register 1 (instruction bits 22:19)
- dec_rs2  in  4  source register 2 (instruction bits 18:15)
- dec_rd  in  4  destination register (instruction bits 26:23)
- dec_use_rs1  in  1  instruction reads rs1
- dec_use_rs2  in  1  instruction reads rs2
- dec_rwrite  in  1  instruction writes rd (control-unit RWrite)
- branch_taken  in  1  decode-stage branch taken (PCSelect)
- freeze  in  1  global pipeline freeze request (multi-cycle memory wait)
- stall_fetch  out  1  hold PC and fetch/decode register
- bubble  out  1  zero the control fields loaded into the decode/execute register
- flush_fetch  out  1  load NOP into the fetch/decode register at the next edge
- pipe_en  out  1  enable for execute/mem/writeback registers
- busy_mask  out  NREGS  bit i = register i has a pending write

Behaviour:
- Reset: clk edge with reset==0 clears all counters and sets FSM=RUN. While reset is low, outputs are stall_fetch=0, flush_fetch=0, pipe_en=1, bubble=1, busy_mask=0.
- Scoreboard: one counter per register, width clog2(WB_LAT+1), holding pending cycles. busy_mask[i] = (cnt[i]!=0).
- Effective valid: v = dec_valid & (state==RUN).
- Hazard: haz = v & ((dec_use_rs1 & cnt[dec_rs1]!=0) | (dec_use_rs2 & cnt[dec_rs2]!=0)).
- Issue: issue = v & ~haz & ~freeze.
- All outputs are combinational from state, counters and inputs, so they are valid in the same cycle.
- Per edge, when freeze==0:
  - Every nonzero counter decrements by 1.
  - If issue & dec_rwrite, cnt[dec_rd] is loaded with WB_LAT. The load overrides the decrement on the same register.
- Freeze==1:
  - Counters and FSM hold.
  - stall_fetch=1, pipe_en=0, bubble=0, flush_fetch=0.
  - No issue is recorded and branch_taken is ignored.
- Timing: a producer issued at edge E0 lets a dependent instruction issue at edge E0+WB_LAT+1. With WB_LAT=3, the consumer sits stalled in decode for exactly 3 cycles.
- FSM:
  - RUN: if issue & branch_taken, assert flush_fetch=1 this cycle and go to FLUSH. A branch blocked by haz has branch_taken ignored until it issues.
  - FLUSH: one cycle. The decode slot is treated as invalid, so bubble=1 and no issue occurs. Returns to RUN unless freeze holds it.
- Output equations when freeze==0:
  - stall_fetch = haz
  - bubble = haz | ~v
  - pipe_en = 1
  - flush_fetch as defined in RUN above.
- Simultaneous events:
  - A hazard and a taken branch in the same cycle: the stall wins, and no flush occurs.
  - A write to a register that is already pending reloads its counter to WB_LAT, so the latest writer governs.
  - An instruction with rd equal to rs1 is checked against the old count before the reload.
- Reset asserted mid-stall or mid-FLUSH clears everything at that edge. The next cycle runs as after power-up.

Optional Feature:
- Macro: HAZ_PERF_EN.
- When defined, adds output ports stall_cycles[15:0] and flush_count[15:0]:
  - stall_cycles increments on every cycle with haz & ~freeze.
  - flush_count increments on every RUN to FLUSH transition.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset held low for 2 cycles, then released with dec_valid=0 -> busy_mask=0, bubble=1, stall_fetch=0, pipe_en=1.
- Issue rd=5 with rwrite; next cycle rs1=5 with use_rs1 -> stall_fetch=1 for exactly 3 cycles, busy_mask[5]=1 over those cycles, consumer issues on the 4th cycle.
- Back-to-back writes to rd=7 one cycle apart -> busy_mask[7] stays 1 for 4 cycles after the first issue; a reader of r7 stalls until counter 0.
- Taken branch with no hazard -> flush_fetch=1 in the branch cycle, bubble=1 the next cycle, flush_count=1 with HAZ_PERF_EN.
- Branch reading r3 two cycles after r3 producer -> stall 2 cycles, flush_fetch only on the issuing cycle.
- freeze=1 for 4 cycles during a 3-cycle stall -> counters frozen, pipe_en=0, total stall extends by 4; reset low mid-stall -> busy_mask=0 next cycle.

Source files
------------

// File: rtl/hazard_scheduler.sv
// hazard_scheduler
//   Pipeline hazard controller for the 5-stage core (no forwarding).
//   It keeps one pending-write countdown per architectural register and
//   stalls decode on read-after-write hazards. After a taken branch issues
//   out of decode, it flushes the wrong-path fetch slot. While the global
//   freeze is active, it holds all state.
//
// Ports
//   clk           core clock
//   reset         synchronous, active-low reset
//   dec_valid     decode slot holds a real instruction
//   dec_rs1/rs2   source registers; dec_use_rs1/rs2 qualify them
//   dec_rd        destination register; dec_rwrite qualifies it
//   branch_taken  decode-stage branch taken (PCSelect)
//   freeze        global pipeline freeze (multi-cycle memory wait)
//   stall_fetch   hold PC and the fetch/decode register
//   bubble        zero control fields entering the decode/execute register
//   flush_fetch   load NOP into the fetch/decode register at the next edge
//   pipe_en       enable for the execute/mem/writeback registers
//   busy_mask     bit i set while register i has a pending write
//
// Optional build macro HAZ_PERF_EN
//   Adds the saturating 16-bit counters stall_cycles and flush_count.
module hazard_scheduler #(
  parameter int NREGS  = 16,
  parameter int REG_AW = 4,
  parameter int WB_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic              dec_rwrite,
  input  logic              branch_taken,
  input  logic              freeze,
  output logic              stall_fetch,
  output logic              bubble,
  output logic              flush_fetch,
  output logic              pipe_en,
  output logic [NREGS-1:0]  busy_mask
`ifdef HAZ_PERF_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  localparam int CW = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(WB_LAT);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt [NREGS];
  logic [NREGS-1:0] pend;
  logic            v, haz, issue;

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      pend[i] = (cnt[i] != '0);
    end
  end

  assign v     = dec_valid & (state == RUN);
  // Lookups use the count before any same-edge reload, so rd==rs1 sees
  // the older writer.
  assign haz   = v & ((dec_use_rs1 & pend[dec_rs1]) | (dec_use_rs2 & pend[dec_rs2]));
  assign issue = v & ~haz & ~freeze;

  // Scoreboard countdowns.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        cnt[i] <= '0;
      end
    end else if (!freeze) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
      // The later assignment wins, so the reload overrides the decrement.
      if (issue & dec_rwrite) begin
        cnt[dec_rd] <= LAT;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    if (!freeze) begin
      case (state)
        RUN:     if (issue & branch_taken) state_nx = FLUSH;
        FLUSH:   state_nx = RUN;
        default: state_nx = RUN;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    stall_fetch = 1'b0;
    bubble      = 1'b1;
    flush_fetch = 1'b0;
    pipe_en     = 1'b1;
    busy_mask   = '0;
    if (reset) begin
      busy_mask = pend;
      if (freeze) begin
        stall_fetch = 1'b1;
        bubble      = 1'b0;
        pipe_en     = 1'b0;
      end else begin
        stall_fetch = haz;
        bubble      = haz | ~v;
        flush_fetch = (state == RUN) & issue & branch_taken;
      end
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (haz && !freeze && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (state == RUN && state_nx == FLUSH && flush_count != '1) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [3:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_rwrite;
  logic        branch_taken, freeze;
  logic        stall_fetch, bubble, flush_fetch, pipe_en;
  logic [15:0] busy_mask;
`ifdef HAZ_PERF_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  hazard_scheduler #(.NREGS(16), .REG_AW(4), .WB_LAT(3)) dut (
    .clk(clk),
    .reset(reset),
    .dec_valid(dec_valid),
    .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2),
    .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2),
    .dec_rwrite(dec_rwrite),
    .branch_taken(branch_taken),
    .freeze(freeze),
    .stall_fetch(stall_fetch),
    .bubble(bubble),
    .flush_fetch(flush_fetch),
    .pipe_en(pipe_en),
    .busy_mask(busy_mask)
`ifdef HAZ_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        s, b, f, p;
    logic [15:0] busy;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: compares combinational outputs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.tag, "/stall"},  32'(stall_fetch), 32'(e.s));
        check({e.tag, "/bubble"}, 32'(bubble),      32'(e.b));
        check({e.tag, "/flush"},  32'(flush_fetch), 32'(e.f));
        check({e.tag, "/pipe_en"},32'(pipe_en),     32'(e.p));
        check({e.tag, "/busy"},   32'(busy_mask),   32'(e.busy));
      end
    end
  end

  // One decode cycle: apply inputs, queue expected outputs, advance one edge.
  task automatic cyc(input string tag, input logic rst, input logic v,
                     input logic [3:0] rs1, input logic u1,
                     input logic [3:0] rs2, input logic u2,
                     input logic [3:0] rd, input logic rw,
                     input logic br, input logic frz,
                     input logic es, input logic eb, input logic ef, input logic ep,
                     input logic [15:0] ebusy);
    exp_t e;
    reset = rst; dec_valid = v;
    dec_rs1 = rs1; dec_use_rs1 = u1;
    dec_rs2 = rs2; dec_use_rs2 = u2;
    dec_rd = rd; dec_rwrite = rw;
    branch_taken = br; freeze = frz;
    e.tag = tag; e.s = es; e.b = eb; e.f = ef; e.p = ep; e.busy = ebusy;
    q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] B3 = 16'h0008, B5 = 16'h0020, B7 = 16'h0080,
                          B9 = 16'h0200, B12 = 16'h1000;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_rwrite = 1'b0;
    branch_taken = 1'b0; freeze = 1'b0;
    @(posedge clk); #1;

    //   tag       rst v  rs1 u1 rs2 u2 rd rw br fz   st bu fl pe busy
    cyc("rst0",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, '0);
    cyc("rst1",    0, 1, 0, 0, 0, 0, 0, 1, 1, 0,   0, 1, 0, 1, '0);
    cyc("idle",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, '0);

    // RAW on r5: three stall cycles, consumer issues on the fourth.
    cyc("p5",      1, 1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 1, '0);
    cyc("c5a",     1, 1, 5, 1, 0, 0, 6, 0, 0, 0,   1, 1, 0, 1, B5);
    cyc("c5b",     1, 1, 5, 1, 0, 0, 6, 0, 0, 0,   1, 1, 0, 1, B5);
    cyc("c5c",     1, 1, 5, 1, 0, 0, 6, 0, 0, 0,   1, 1, 0, 1, B5);
    cyc("c5go",    1, 1, 5, 1, 0, 0, 6, 0, 0, 0,   0, 0, 0, 1, '0);

    // Back-to-back writers of r7; the second reload governs.
    cyc("w7a",     1, 1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 0, 1, '0);
    cyc("w7b",     1, 1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 0, 1, B7);
    cyc("r7a",     1, 1, 0, 0, 7, 1, 1, 0, 0, 0,   1, 1, 0, 1, B7);
    cyc("r7b",     1, 1, 0, 0, 7, 1, 1, 0, 0, 0,   1, 1, 0, 1, B7);
    cyc("r7c",     1, 1, 0, 0, 7, 1, 1, 0, 0, 0,   1, 1, 0, 1, B7);
    cyc("r7go",    1, 1, 0, 0, 7, 1, 1, 0, 0, 0,   0, 0, 0, 1, '0);

    // Taken branch without hazard; wrong-path slot is bubbled.
    cyc("br",      1, 1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, '0);
    cyc("brfl",    1, 1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 1, '0);
    cyc("bridle",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, '0);

    // Branch reading r3 two cycles after its producer.
    cyc("p3",      1, 1, 0, 0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 1, '0);
    cyc("gap3",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, B3);
    cyc("b3a",     1, 1, 3, 1, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1, B3);
    cyc("b3b",     1, 1, 3, 1, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1, B3);
    cyc("b3go",    1, 1, 3, 1, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, '0);
    cyc("b3fl",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, '0);

    // Freeze for 4 cycles in the middle of a stall on r9.
    cyc("p9",      1, 1, 0, 0, 0, 0, 9, 1, 0, 0,   0, 0, 0, 1, '0);
    cyc("c9a",     1, 1, 9, 1, 0, 0, 2, 0, 0, 0,   1, 1, 0, 1, B9);
    for (int i = 0; i < 4; i++)
      cyc("c9frz", 1, 1, 9, 1, 0, 0, 2, 0, 0, 1,   1, 0, 0, 0, B9);
    cyc("c9b",     1, 1, 9, 1, 0, 0, 2, 0, 0, 0,   1, 1, 0, 1, B9);
    cyc("c9c",     1, 1, 9, 1, 0, 0, 2, 0, 0, 0,   1, 1, 0, 1, B9);
    cyc("c9go",    1, 1, 9, 1, 0, 0, 2, 0, 0, 0,   0, 0, 0, 1, '0);

    // Branch under freeze is ignored, then taken once freeze drops.
    cyc("brfrz",   1, 1, 0, 0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0, '0);
    cyc("brgo",    1, 1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, '0);
    cyc("brgofl",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, '0);

`ifdef HAZ_PERF_EN
    check("perf/stall_cycles", 32'(stall_cycles), 32'd11);
    check("perf/flush_count",  32'(flush_count),  32'd3);
`endif

    // Reset in the middle of a stall clears the scoreboard.
    cyc("p12",     1, 1, 0, 0, 0, 0, 12, 1, 0, 0,  0, 0, 0, 1, '0);
    cyc("c12a",    1, 1, 12, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, B12);
    cyc("c12rst",  0, 1, 12, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, '0);
    cyc("c12go",   1, 1, 12, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, '0);

`ifdef HAZ_PERF_EN
    check("perf/stall_clr", 32'(stall_cycles), 32'd0);
    check("perf/flush_clr", 32'(flush_count),  32'd0);
`endif

    check("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
